// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//
// Registered immediate generator for the decode-to-execute path of the
// pipelined RV core. A raw instruction word and an ImmSel format code are
// accepted through a valid/ready handshake. The sign- or zero-extended
// XLEN-wide immediate appears one clock later, together with the sideband tag
// that entered with it.
//
// Storage is a main slot, which drives the outputs, and a skid slot. Because
// of the skid slot, in_ready depends only on registered state (it is simply
// "skid slot empty"), yet back-pressure never drops or duplicates an entry.
//
// Parameters:
//   XLEN   datapath width, 32 or 64
//   TAG_W  width of the sideband tag
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   flush        synchronous flush, discards every held entry
//   in_valid     input entry present
//   in_ready     block can accept an input this cycle
//   instr        raw 32-bit instruction word
//   ImmSel       immediate format select (0 I, 1 S, 2 B, 3 U, 4 J, 5 shamt,
//                6 CSR zimm, 7 none)
//   in_tag       sideband tag of the input entry
//   out_valid    output entry present
//   out_ready    consumer accepts the output this cycle
//   imm          generated immediate
//   out_tag      tag of the output entry
//   out_illegal  set for ImmSel=7 entries when IMM_GEN_ILLEGAL_EN is defined
//
// Build option:
//   IMM_GEN_ILLEGAL_EN  when defined, ImmSel=7 entries carry out_illegal=1.
//                       When undefined, out_illegal is always 0. The handshake
//                       and timing are the same in both builds.
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       ImmSel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  typedef enum logic [2:0] {
    SEL_I     = 3'd0,
    SEL_S     = 3'd1,
    SEL_B     = 3'd2,
    SEL_U     = 3'd3,
    SEL_J     = 3'd4,
    SEL_SHAMT = 3'd5,
    SEL_ZIMM  = 3'd6,
    SEL_NONE  = 3'd7
  } imm_sel_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Immediate decode (combinational, ahead of the slot registers)
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;
  entry_t          new_entry;

  // The opcode field never contributes to any immediate format.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  // NOTE: every signal written in always_comb is given a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    dec_imm = '0;
    case (imm_sel_e'(ImmSel))
      SEL_I:     dec_imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      SEL_S:     dec_imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      SEL_B:     dec_imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
      SEL_U:     dec_imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
      SEL_J:     dec_imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                            instr[20], instr[30:21], 1'b0};
      SEL_SHAMT: begin
        // RV64 shift amounts are 6 bits wide; RV32 uses only 5.
        if (XLEN == 64) dec_imm = {{(XLEN-6){1'b0}}, instr[25:20]};
        else            dec_imm = {{(XLEN-5){1'b0}}, instr[24:20]};
      end
      SEL_ZIMM:  dec_imm = {{(XLEN-5){1'b0}}, instr[19:15]};
      default:   dec_imm = '0;
    endcase
  end

`ifdef IMM_GEN_ILLEGAL_EN
  assign dec_illegal = (ImmSel == SEL_NONE);
`else
  assign dec_illegal = 1'b0;
`endif

  assign new_entry = '{imm: dec_imm, tag: in_tag, illegal: dec_illegal};

  // ---------------------------------------------------------------------------
  // Main / skid slots
  // ---------------------------------------------------------------------------
  logic   m_valid;
  logic   s_valid;
  entry_t m_entry;
  entry_t s_entry;

  logic accept;
  logic m_free;

  assign in_ready = !s_valid;
  assign accept   = in_valid && in_ready;
  // Main slot can take a new entry this edge: it is empty or being consumed.
  assign m_free   = !m_valid || out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (m_free) begin
      if (s_valid) begin
        // Skid refills main; in_ready is low, so nothing is accepted.
        m_valid <= 1'b1;
        s_valid <= 1'b0;
      end else begin
        m_valid <= accept;
      end
    end else if (accept) begin
      // Main is stalled: the new entry parks in the skid slot.
      s_valid <= 1'b1;
    end
  end

  // NOTE: payload registers are reset too, because imm/out_tag/out_illegal
  // must read 0 out of reset even though out_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_entry <= '0;
      s_entry <= '0;
    end else if (m_free) begin
      if (s_valid)     m_entry <= s_entry;
      else if (accept) m_entry <= new_entry;
    end else if (accept) begin
      s_entry <= new_entry;
    end
  end

  assign out_valid   = m_valid;
  assign imm         = m_entry.imm;
  assign out_tag     = m_entry.tag;
  assign out_illegal = m_entry.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
//
// Directed bench for imm_gen_pipe. Two instances share one stimulus: an
// XLEN=32 unit (full handshake checks) and an XLEN=64 unit (wide extension
// checks). Inputs change 1 ns after each rising edge and outputs are sampled
// at that same point, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;

  localparam int TAG_W = 5;
  localparam logic [31:0] INSTR = 32'h952F0F3A;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [2:0]       ImmSel;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  logic             in_ready_64;
  logic             out_valid_64;
  logic [63:0]      imm_64;
  logic [TAG_W-1:0] out_tag_64;
  logic             out_illegal_64;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .ImmSel(ImmSel), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .imm(imm), .out_tag(out_tag), .out_illegal(out_illegal)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut_64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_64),
    .instr(instr), .ImmSel(ImmSel), .in_tag(in_tag),
    .out_valid(out_valid_64), .out_ready(out_ready),
    .imm(imm_64), .out_tag(out_tag_64), .out_illegal(out_illegal_64)
  );

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // One rising edge, then settle to the sampling/driving point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] sel,
                       input logic [TAG_W-1:0] tag);
    in_valid = v;
    ImmSel   = sel;
    in_tag   = tag;
  endtask

  // Hand-computed immediates for INSTR, ImmSel 0..6.
  logic [31:0] exp32 [7] = '{32'hFFFFF952, 32'hFFFFF95E, 32'hFFFFF15E,
                             32'h952F0000, 32'hFFFF0152, 32'h00000012,
                             32'h0000001E};
  logic [63:0] exp64 [7] = '{64'hFFFFFFFFFFFFF952, 64'hFFFFFFFFFFFFF95E,
                             64'hFFFFFFFFFFFFF15E, 64'hFFFFFFFF952F0000,
                             64'hFFFFFFFFFFFF0152, 64'h0000000000000012,
                             64'h000000000000001E};

`ifdef IMM_GEN_ILLEGAL_EN
  localparam logic EXP_ILLEGAL = 1'b1;
`else
  localparam logic EXP_ILLEGAL = 1'b0;
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    instr = INSTR; drive(1'b0, 3'd0, '0);
    #12;
    // Reset state
    check("rst_out_valid",   out_valid,   0);
    check("rst_imm",         imm,         0);
    check("rst_out_tag",     out_tag,     0);
    check("rst_out_illegal", out_illegal, 0);
    check("rst_in_ready",    in_ready,    1);
    check("rst_imm_64",      imm_64,      0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    // 1) All formats back to back with no back-pressure.
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 3'(i), TAG_W'(i));
      step();
      check($sformatf("fmt%0d_valid", i), out_valid, 1);
      check($sformatf("fmt%0d_imm", i),   imm,       exp32[i]);
      check($sformatf("fmt%0d_tag", i),   out_tag,   i);
      check($sformatf("fmt%0d_ready", i), in_ready,  1);
      // 5) XLEN=64 extension of the same vectors
      check($sformatf("fmt%0d_imm64", i), imm_64,    exp64[i]);
    end
    drive(1'b0, 3'd0, '0);
    step();
    check("fmt_drained", out_valid, 0);

    // 2) Back-pressure fills main then skid; release drains in order.
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 5'd1);
    step();
    check("bp_m_valid",  out_valid, 1);
    check("bp_m_ready",  in_ready,  1);
    drive(1'b1, 3'd1, 5'd2);
    step();
    check("bp_s_ready",  in_ready,  0);
    drive(1'b0, 3'd0, '0);
    step();
    check("bp_hold_valid", out_valid, 1);
    check("bp_hold_imm",   imm,       32'hFFFFF952);
    check("bp_hold_tag",   out_tag,   1);
    out_ready = 1'b1;
    step();
    check("bp_2nd_valid", out_valid, 1);
    check("bp_2nd_imm",   imm,       32'hFFFFF95E);
    check("bp_2nd_tag",   out_tag,   2);
    check("bp_2nd_ready", in_ready,  1);
    step();
    check("bp_empty", out_valid, 0);

    // 3) Flush with both slots full and an input offered.
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 5'd3); step();
    drive(1'b1, 3'd1, 5'd4); step();
    check("fl_full_ready", in_ready, 0);
    drive(1'b1, 3'd2, 5'd5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 3'd0, '0);
    check("fl_valid", out_valid, 0);
    check("fl_ready", in_ready,  1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("fl_quiet%0d", i), out_valid, 0);
    end

    // 3b) Input accepted during a flush cycle (skid empty) is discarded.
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 5'd10); step();
    drive(1'b1, 3'd3, 5'd11);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 3'd0, '0);
    out_ready = 1'b1;
    check("fl_acc_valid", out_valid, 0);
    step();
    check("fl_acc_quiet", out_valid, 0);

    // 4) Asynchronous reset while stalled with two entries held.
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 5'd6); step();
    drive(1'b1, 3'd1, 5'd7); step();
    drive(1'b0, 3'd0, '0);
    check("ar_pre_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid",    out_valid, 0);
    check("ar_imm",      imm,       0);
    check("ar_tag",      out_tag,   0);
    check("ar_in_ready", in_ready,  1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 3'd3, 5'd8);
    step();
    check("ar_post_valid", out_valid, 1);
    check("ar_post_imm",   imm,       32'h952F0000);
    check("ar_post_tag",   out_tag,   8);

    // 6) ImmSel=7, then a legal code right behind it.
    drive(1'b1, 3'd7, 5'd9);
    step();
    check("sel7_valid",   out_valid,   1);
    check("sel7_imm",     imm,         0);
    check("sel7_illegal", out_illegal, EXP_ILLEGAL);
    check("sel7_tag",     out_tag,     9);
    check("sel7_imm64",   imm_64,      0);
    drive(1'b1, 3'd0, 5'd12);
    step();
    check("sel0_illegal", out_illegal, 0);
    check("sel0_imm",     imm,         32'hFFFFF952);
    drive(1'b0, 3'd0, '0);
    step();
    check("end_empty", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
